// File: rtl/sync_frame_fifo_pkg.sv
// Shared types and constants for the store-and-forward frame FIFO.
package sync_frame_fifo_pkg;

   localparam int unsigned DROP_CNT_W = 16;
   localparam int unsigned FIFO_WIDTH = 8;

   // One stored entry: payload byte plus end-of-frame marker.
   typedef struct packed {
      logic                  last;
      logic [FIFO_WIDTH-1:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// Single write port, asynchronous read port memory (distributed RAM style).
module sync_fifo_ram #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 64,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
)(
   input  logic              i_clk,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [WIDTH-1:0]  i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [WIDTH-1:0]  o_rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_frame_fifo.sv
// Single-clock store-and-forward FIFO: frames become readable only once committed,
// and a frame is discarded on request or on overflow so the reader never sees a partial one.
module sync_frame_fifo
   import sync_frame_fifo_pkg::*;
#(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned DEPTH        = 64,
   parameter bit          FRAME_MODE   = 1'b1,
   parameter int unsigned AFULL_THRESH = DEPTH - 4,
   localparam int unsigned PTR_W       = $clog2(DEPTH)
)(
   input  logic                  clkIn,
   input  logic                  rstNIn,
   input  logic                  wrEnIn,
   input  logic [WIDTH-1:0]      wrDataIn,
   input  logic                  wrLastIn,
   input  logic                  wrDropIn,
   output logic                  wrFullOut,
   output logic                  wrAlmostFullOut,
   output logic [PTR_W:0]        wrUsedOut,
   output logic                  overflowOut,
   output logic [DROP_CNT_W-1:0] dropCntOut,
   input  logic                  rdReadyIn,
   output logic [WIDTH-1:0]      rdDataOut,
   output logic                  rdLastOut,
   output logic                  rdValidOut,
   output logic [PTR_W:0]        rdCountOut
);

   localparam int unsigned PTR_CW = PTR_W + 1;

   typedef struct packed {
      logic             last;
      logic [WIDTH-1:0] data;
   } entry_t;

   logic [PTR_CW-1:0]     r_wr_ptr, r_cmt_ptr, r_rd_ptr;
   logic                  r_discard, r_overflow;
   logic [DROP_CNT_W-1:0] r_drop_cnt;
   logic                  r_valid, r_full, r_afull;
   logic [PTR_CW-1:0]     r_used, r_count;

   logic [PTR_CW-1:0] w_wr_nxt, w_cmt_nxt, w_rd_nxt, w_used_nxt;
   logic              w_discard_nxt, w_overflow_nxt, w_drop_inc;
   logic              w_full, w_wr_acc, w_rd_fire, w_mem_we;
   entry_t            w_wr_entry, w_rd_entry;
   logic [WIDTH:0]    w_wr_raw, w_rd_raw;

   assign w_full    = (r_wr_ptr - r_rd_ptr) == PTR_CW'(DEPTH);
   assign w_wr_acc  = wrEnIn & ~w_full & ~r_discard;
   assign w_rd_fire = r_valid & rdReadyIn;
   // A dropped byte never reaches memory, even though its slot would be free.
   assign w_mem_we  = w_wr_acc & ~(FRAME_MODE & wrDropIn);

   // Next pointer / discard / overflow state; drop outranks overflow, which outranks a write.
   always_comb begin
      w_wr_nxt       = r_wr_ptr;
      w_cmt_nxt      = r_cmt_ptr;
      w_rd_nxt       = r_rd_ptr;
      w_discard_nxt  = r_discard;
      w_overflow_nxt = r_overflow;
      w_drop_inc     = 1'b0;

      if (w_rd_fire) begin
         w_rd_nxt = r_rd_ptr + PTR_CW'(1);
      end
      if (wrEnIn && w_full && !r_discard) begin
         w_overflow_nxt = 1'b1;
      end

      if (FRAME_MODE) begin
         if (r_discard) begin
            if (wrEnIn && wrLastIn) begin
               w_discard_nxt = 1'b0;
            end
         end else if (wrDropIn) begin
            w_wr_nxt   = r_cmt_ptr;
            w_drop_inc = 1'b1;
         end else if (wrEnIn && w_full) begin
            // An overflow that lands on the last byte ends the frame; no discard needed.
            w_wr_nxt      = r_cmt_ptr;
            w_drop_inc    = 1'b1;
            w_discard_nxt = ~wrLastIn;
         end else if (w_wr_acc) begin
            w_wr_nxt = r_wr_ptr + PTR_CW'(1);
            if (wrLastIn) begin
               w_cmt_nxt = r_wr_ptr + PTR_CW'(1);
            end
         end
      end else begin
         if (w_wr_acc) begin
            w_wr_nxt = r_wr_ptr + PTR_CW'(1);
         end
         w_cmt_nxt = w_wr_nxt;
      end
   end

   assign w_used_nxt = w_wr_nxt - w_rd_nxt;

   always_ff @(posedge clkIn) begin
      if (!rstNIn) begin
         r_wr_ptr   <= '0;
         r_cmt_ptr  <= '0;
         r_rd_ptr   <= '0;
         r_discard  <= 1'b0;
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
         r_valid    <= 1'b0;
         r_full     <= 1'b0;
         r_afull    <= 1'b0;
         r_used     <= '0;
         r_count    <= '0;
      end else begin
         r_wr_ptr   <= w_wr_nxt;
         r_cmt_ptr  <= w_cmt_nxt;
         r_rd_ptr   <= w_rd_nxt;
         r_discard  <= w_discard_nxt;
         r_overflow <= w_overflow_nxt;
         if (w_drop_inc && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
         end
         r_valid    <= (w_cmt_nxt != w_rd_nxt);
         r_full     <= (w_used_nxt == PTR_CW'(DEPTH));
         r_afull    <= (w_used_nxt >= PTR_CW'(AFULL_THRESH));
         r_used     <= w_used_nxt;
         r_count    <= w_cmt_nxt - w_rd_nxt;
      end
   end

   assign w_wr_entry = '{last: wrLastIn, data: wrDataIn};
   assign w_wr_raw   = w_wr_entry;

   sync_fifo_ram #(
      .WIDTH (WIDTH + 1),
      .DEPTH (DEPTH)
   ) u_ram (
      .i_clk     (clkIn),
      .i_wr_en   (w_mem_we),
      .i_wr_addr (r_wr_ptr[PTR_W-1:0]),
      .i_wr_data (w_wr_raw),
      .i_rd_addr (r_rd_ptr[PTR_W-1:0]),
      .o_rd_data (w_rd_raw)
   );

   assign w_rd_entry = entry_t'(w_rd_raw);

   assign wrFullOut       = r_full;
   assign wrAlmostFullOut = r_afull;
   assign wrUsedOut       = r_used;
   assign overflowOut     = r_overflow;
   assign dropCntOut      = r_drop_cnt;
   assign rdValidOut      = r_valid;
   assign rdCountOut      = r_count;
   assign rdDataOut       = w_rd_entry.data;
   assign rdLastOut       = r_valid & w_rd_entry.last;

endmodule

// File: tb/tb_sync_frame_fifo.sv
// Scoreboard bench for sync_frame_fifo: a queue-based frame model predicts state and read data.
module tb_sync_frame_fifo;
   import sync_frame_fifo_pkg::*;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned PW    = $clog2(DEPTH);
   localparam int unsigned AFT   = DEPTH - 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #2 clk = ~clk;

   // frame-mode instance
   logic        f_wr_en = 1'b0, f_wr_last = 1'b0, f_wr_drop = 1'b0, f_rd_ready = 1'b0;
   logic [7:0]  f_wr_data = '0;
   logic        f_full, f_afull, f_ovf, f_rd_last, f_rd_valid;
   logic [PW:0] f_used, f_count;
   logic [15:0] f_dcnt;
   logic [7:0]  f_rd_data;

   // plain-FIFO instance
   logic        p_wr_en = 1'b0, p_wr_last = 1'b0, p_wr_drop = 1'b0, p_rd_ready = 1'b0;
   logic [7:0]  p_wr_data = '0;
   logic        p_full, p_afull, p_ovf, p_rd_last, p_rd_valid;
   logic [PW:0] p_used, p_count;
   logic [15:0] p_dcnt;
   logic [7:0]  p_rd_data;

   sync_frame_fifo #(.WIDTH(8), .DEPTH(DEPTH), .FRAME_MODE(1'b1), .AFULL_THRESH(AFT)) u_frame (
      .clkIn(clk), .rstNIn(rst_n),
      .wrEnIn(f_wr_en), .wrDataIn(f_wr_data), .wrLastIn(f_wr_last), .wrDropIn(f_wr_drop),
      .wrFullOut(f_full), .wrAlmostFullOut(f_afull), .wrUsedOut(f_used),
      .overflowOut(f_ovf), .dropCntOut(f_dcnt),
      .rdReadyIn(f_rd_ready), .rdDataOut(f_rd_data), .rdLastOut(f_rd_last),
      .rdValidOut(f_rd_valid), .rdCountOut(f_count)
   );

   sync_frame_fifo #(.WIDTH(8), .DEPTH(DEPTH), .FRAME_MODE(1'b0), .AFULL_THRESH(AFT)) u_plain (
      .clkIn(clk), .rstNIn(rst_n),
      .wrEnIn(p_wr_en), .wrDataIn(p_wr_data), .wrLastIn(p_wr_last), .wrDropIn(p_wr_drop),
      .wrFullOut(p_full), .wrAlmostFullOut(p_afull), .wrUsedOut(p_used),
      .overflowOut(p_ovf), .dropCntOut(p_dcnt),
      .rdReadyIn(p_rd_ready), .rdDataOut(p_rd_data), .rdLastOut(p_rd_last),
      .rdValidOut(p_rd_valid), .rdCountOut(p_count)
   );

   int n_tests = 0;
   int n_fail  = 0;

   function automatic void chk(string nm, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
      end
   endfunction

   // Reference model: committed-entry count, pending frame bytes, discard flag, sticky flags.
   int          m_cmt  = 0;
   fifo_entry_t m_pend[$];
   fifo_entry_t sb[$];
   bit          m_disc = 1'b0;
   bit          m_ovf  = 1'b0;
   int          m_dcnt = 0;

   function automatic void model_reset();
      m_cmt  = 0;
      m_pend.delete();
      sb.delete();
      m_disc = 1'b0;
      m_ovf  = 1'b0;
      m_dcnt = 0;
   endfunction

   function automatic void model_drop();
      m_pend.delete();
      if (m_dcnt < 65535) m_dcnt++;
   endfunction

   function automatic void model_step(bit en, logic [7:0] d, bit last, bit drop, bit rdy);
      int used;
      bit full, rd;
      used = m_cmt + m_pend.size();
      full = (used == int'(DEPTH));
      rd   = (m_cmt > 0) && rdy;
      if (m_disc) begin
         if (en && last) m_disc = 1'b0;
      end else if (drop) begin
         if (en && full) m_ovf = 1'b1;
         model_drop();
      end else if (en && full) begin
         m_ovf = 1'b1;
         model_drop();
         m_disc = !last;
      end else if (en) begin
         m_pend.push_back('{last: last, data: d});
         if (last) begin
            foreach (m_pend[k]) sb.push_back(m_pend[k]);
            m_cmt += m_pend.size();
            m_pend.delete();
         end
      end
      if (rd) m_cmt--;
   endfunction

   function automatic void check_state();
      int used;
      used = m_cmt + m_pend.size();
      chk("rd_count", int'(f_count), m_cmt);
      chk("wr_used",  int'(f_used), used);
      chk("rd_valid", int'(f_rd_valid), int'(m_cmt != 0));
      chk("wr_full",  int'(f_full), int'(used == int'(DEPTH)));
      chk("wr_afull", int'(f_afull), int'(used >= int'(AFT)));
      chk("overflow", int'(f_ovf), int'(m_ovf));
      chk("drop_cnt", int'(f_dcnt), m_dcnt);
      if (m_cmt == 0) chk("rd_last_idle", int'(f_rd_last), 0);
   endfunction

   task automatic cycle(input bit en, input logic [7:0] d, input bit last, input bit drop, input bit rdy);
      f_wr_en = en; f_wr_data = d; f_wr_last = last; f_wr_drop = drop; f_rd_ready = rdy;
      @(posedge clk);
      model_step(en, d, last, drop, rdy);
      #1;
      check_state();
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int k = 0; k < n; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0, rdy);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      f_wr_en = 1'b0; f_wr_last = 1'b0; f_wr_drop = 1'b0; f_rd_ready = 1'b0;
      p_wr_en = 1'b0; p_wr_last = 1'b0; p_wr_drop = 1'b0; p_rd_ready = 1'b0;
      @(posedge clk);
      model_reset();
      #1;
      rst_n = 1'b1;
      check_state();
      chk("rst_rd_last", int'(f_rd_last), 0);
      chk("rst_plain_valid", int'(p_rd_valid), 0);
      chk("rst_plain_used", int'(p_used), 0);
   endtask

   // Monitor: each word the consumer takes must be the oldest committed entry.
   always @(negedge clk) begin
      if (rst_n && f_rd_valid && f_rd_ready) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty: read data 0x%0h while nothing was expected at %0t", f_rd_data, $time);
         end else begin
            fifo_entry_t e;
            e = sb.pop_front();
            chk("rd_data", int'(f_rd_data), int'(e.data));
            chk("rd_last", int'(f_rd_last), int'(e.last));
         end
      end
   end

   initial begin
      do_reset();
      do_reset();

      // single frame A0..A3
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hA0 + i), (i == 3), 1'b0, 1'b1);
      chk("single_count4", int'(f_count), 4);
      idle(6, 1'b1);

      // drop after 3 bytes
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      chk("drop_used", int'(f_used), 0);
      chk("drop_cnt1", int'(f_dcnt), 1);
      idle(2, 1'b1);

      // 20-byte frame into a 16-deep FIFO
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 8'(8'h40 + i), (i == 19), 1'b0, 1'b0);
         if (i == 15) chk("ovf_full16", int'(f_full), 1);
      end
      chk("ovf_flag", int'(f_ovf), 1);
      chk("ovf_valid", int'(f_rd_valid), 0);
      chk("ovf_dcnt", int'(f_dcnt), 2);
      cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h78, 1'b1, 1'b0, 1'b0);
      chk("ovf_next_count", int'(f_count), 2);
      idle(4, 1'b1);

      // concurrency: hold 8 committed while streaming single-byte frames
      for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h60 + i), (i == 7), 1'b0, 1'b0);
      for (int i = 0; i < 100; i++) begin
         cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b1);
         chk("conc_range", int'((f_count >= 7) && (f_count <= 9)), 1);
      end
      idle(12, 1'b1);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         bit en, last, drop, rdy;
         en   = ($urandom_range(0, 9) < 7);
         last = ($urandom_range(0, 5) == 0);
         drop = ($urandom_range(0, 29) == 0);
         rdy  = ($urandom_range(0, 9) < 6);
         cycle(en, 8'($urandom), last, drop, rdy);
      end
      idle(DEPTH + 4, 1'b1);
      chk("rand_drained", int'(f_count), 0);

      // reset mid-frame with committed data partially read
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), (i == 4), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0, 1'b1);
      do_reset();
      chk("mid_rst_count", int'(f_count), 0);
      chk("mid_rst_used", int'(f_used), 0);
      chk("mid_rst_valid", int'(f_rd_valid), 0);
      chk("mid_rst_ovf", int'(f_ovf), 0);
      chk("mid_rst_dcnt", int'(f_dcnt), 0);

      // plain FIFO: last/drop ignored, immediate visibility
      p_wr_en = 1'b1; p_wr_data = 8'h11; p_wr_last = 1'b0; p_wr_drop = 1'b1;
      idle(1, 1'b0);
      p_wr_en = 1'b0; p_wr_drop = 1'b0;
      chk("plain_valid", int'(p_rd_valid), 1);
      chk("plain_data", int'(p_rd_data), 8'h11);
      chk("plain_count", int'(p_count), 1);
      chk("plain_dcnt", int'(p_dcnt), 0);
      for (int i = 0; i < 15; i++) begin
         p_wr_en = 1'b1; p_wr_data = 8'(8'h20 + i); p_wr_last = (i == 3); p_wr_drop = (i == 5);
         idle(1, 1'b0);
      end
      chk("plain_full", int'(p_full), 1);
      p_wr_en = 1'b1; p_wr_data = 8'hEE; p_wr_last = 1'b0; p_wr_drop = 1'b0;
      idle(1, 1'b0);
      p_wr_en = 1'b0;
      chk("plain_ovf", int'(p_ovf), 1);
      chk("plain_ovf_count", int'(p_count), 16);
      chk("plain_ovf_dcnt", int'(p_dcnt), 0);
      for (int i = 0; i < 16; i++) begin
         chk("plain_rd_data", int'(p_rd_data), (i == 0) ? 8'h11 : (8'h20 + i - 1));
         p_rd_ready = 1'b1;
         idle(1, 1'b0);
      end
      p_rd_ready = 1'b0;
      chk("plain_empty", int'(p_rd_valid), 0);
      p_wr_en = 1'b1; p_wr_data = 8'h55;
      idle(1, 1'b0);
      p_wr_en = 1'b0;
      chk("plain_after_ovf", int'(p_rd_data), 8'h55);
      chk("plain_after_cnt", int'(p_count), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_frame_fifo.md
Name: sync_frame_fifo

Overview:
Single-clock, parametrised store-and-forward FIFO for the 250 MHz parse domain. It sits between the CDC output and the message parser. It buffers Ethernet payload bytes and releases a frame to the read side only once the whole frame is committed. Frames can be dropped on a bad FCS or overflow, so the parser never sees a partial frame; a plain streaming mode is also provided.

Parameters:
WIDTH, 8, data bits per entry.
DEPTH, 64, entries; power of two, at least 4.
FRAME_MODE, 1'b1; 1 = store-and-forward with commit/drop, 0 = plain FIFO (every accepted write commits immediately; wrLastIn and wrDropIn ignored).
AFULL_THRESH, DEPTH-4, wrAlmostFullOut asserts when used entries >= this value.
PTR_W, $clog2(DEPTH), derived; not overridable.

Ports:
clkIn  in  1  single clock.
rstNIn  in  1  synchronous, active-low reset.
wrEnIn  in  1  write request.
wrDataIn  in  WIDTH  write data.
wrLastIn  in  1  last byte of frame; qualified by wrEnIn.
wrDropIn  in  1  discard the current uncommitted frame; standalone or with the last write.
wrFullOut  out  1  no free entry.
wrAlmostFullOut  out  1  used >= AFULL_THRESH.
wrUsedOut  out  PTR_W+1  entries used, committed plus uncommitted.
overflowOut  out  1  sticky: a write was attempted while full.
dropCntOut  out  16  frames dropped, saturating.
rdReadyIn  in  1  consumer accepts the current word.
rdDataOut  out  WIDTH  FWFT data at the head.
rdLastOut  out  1  head entry is the last byte of its frame.
rdValidOut  out  1  a committed entry is present.
rdCountOut  out  PTR_W+1  committed entries available.

Behaviour:
- Reset (rstNIn = 0 on a clkIn edge) sets all pointers to 0 and clears overflowOut, dropCntOut and the discard state.
  - After reset: rdValidOut = 0, wrFullOut = 0, wrAlmostFullOut = 0, counts = 0, rdLastOut = 0.
  - rdDataOut is don't-care while rdValidOut = 0.
- Storage: DEPTH x (WIDTH+1) entries; the extra bit holds the last flag. Reads are asynchronous (distributed RAM), giving FWFT.
- Pointers are PTR_W+1 bits wide; the MSB is the wrap bit.
  - wrPtr: next write location.
  - cmtPtr: end of committed data.
  - rdPtr: head.
  - Occupancy and counts are computed modulo 2^(PTR_W+1).
  - full = (wrPtr - rdPtr) == DEPTH.
- Write accepted = wrEnIn & ~full & ~discard.
  - On acceptance: mem[wrPtr] <= {wrLastIn, wrDataIn}; wrPtr increments.
- Commit (FRAME_MODE = 1): on an accepted write with wrLastIn = 1 and wrDropIn = 0, cmtPtr <= wrPtr + 1.
  - The data becomes visible (rdValidOut) on the next cycle.
- Drop (FRAME_MODE = 1): wrDropIn = 1 sets wrPtr <= cmtPtr (rewind) and increments dropCntOut.
  - Drop takes priority over a same-cycle write or commit; that byte is discarded.
- Overflow: wrEnIn while full (and not discarding) sets overflowOut (sticky until reset).
  - In frame mode it also enters the discard state: wrPtr is rewound to cmtPtr at once, and all further writes are ignored.
  - The discard state exits on a wrEnIn with wrLastIn; dropCntOut increments once per discarded frame.
  - A frame longer than DEPTH can therefore never deadlock the FIFO.
- FRAME_MODE = 0: cmtPtr tracks wrPtr. An overflowing write is lost, overflowOut sets, and no discard state is entered.
- Read: rdValidOut = (cmtPtr != rdPtr). When rdValidOut & rdReadyIn, rdPtr increments on that edge.
- Simultaneous events:
  - A read and a write in the same cycle are both honoured.
  - A read at full frees the slot only on the following cycle; a same-cycle write at full is refused.
  - A read and a drop in the same cycle are both honoured; rdPtr is never rewound.
- Output timing: wrUsedOut and rdCountOut are registered and reflect pointer state after the edge; latency is 1 cycle.

Decomposition:
- Package pkg gains:
  - the fifo_entry_t struct {logic last; logic [WIDTH-1:0] data}, parametrised via a localparam in the module;
  - the DROP_CNT_W = 16 constant.
- One sub-module, sync_fifo_ram: 1 write / 1 async-read memory, parameters WIDTH and DEPTH.

Test Plan:
- Single frame: write 4 bytes A0..A3 with last on A3 and rdReadyIn = 1. rdValidOut stays 0 until the cycle after A3, then A0..A3 appear on consecutive cycles, rdLastOut = 1 with A3, and rdCountOut goes 4→0.
- Drop: write 3 bytes, then pulse wrDropIn. rdValidOut never rises, wrUsedOut returns to 0, and dropCntOut = 1.
- Overflow, DEPTH = 16: 20-byte frame with rdReadyIn = 0. wrFullOut asserts after 16 writes and overflowOut = 1. Nothing is readable, dropCntOut = 1, and a following 2-byte frame is then read intact.
- Concurrency: keep the FIFO at 8 committed entries and stream read and write every cycle for 100 cycles. Data order is preserved and rdCountOut stays between 7 and 9.
- FRAME_MODE = 0: write 0x11. rdValidOut = 1 on the next cycle; wrLastIn and wrDropIn have no effect.
- Reset mid-frame: drive rstNIn low during a partially written, partially read frame. All counts are 0, rdValidOut = 0, overflowOut = 0 and dropCntOut = 0 on the following cycle.
